mem_access_unit: RTL and testbench

Parametrised load/store unit for the memory stage. It replaces the fixed 64-bit, aligned-only lane logic. Supports XLEN of 32 or 64, byte/half/word/dword accesses with sign or zero extension, and misaligned accesses that cross a bus word, which it splits into two bus beats. It sits between execute and writeback and drives the data-memory port with a req/ack handshake. While an access is in flight it holds the pipeline through `req_ready_out`.

---
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with misaligned split into two bus beats
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32,
    localparam int LANES = XLEN / 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [XLEN-1:0]   store_data_in,
    input  logic [2:0]        width_in,
    input  logic              write_in,
    input  logic [4:0]        rd_in,
    input  logic              flush_in,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [XLEN-1:0]   mem_wdata_out,
    output logic [LANES-1:0]  mem_mask_out,
    input  logic              mem_ack_in,
    input  logic [XLEN-1:0]   mem_rdata_in,
    output logic              wb_valid_out,
    output logic              wb_rd_write_out,
    output logic [4:0]        wb_rd_out,
    output logic [XLEN-1:0]   wb_data_out
);
    localparam int OFF_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
    state_t state;

    logic [ADDR_W-1:0]  a_addr;
    logic [XLEN-1:0]    a_store;
    logic [2:0]         a_width;
    logic               a_write;
    logic [4:0]         a_rd;
    logic               kill;
    logic               wb_valid_q;
    logic [XLEN-1:0]    rd_hold;

    logic [ADDR_W-1:0]  src_addr;
    logic [XLEN-1:0]    src_store;
    logic [2:0]         src_width;
    logic [1:0]         sz;
    int                 nbytes;
    int                 nbits;
    logic [OFF_W-1:0]   off;
    logic [2*LANES-1:0] base_mask;
    logic [2*LANES-1:0] full_mask;
    logic [2*XLEN-1:0]  shifted;
    logic [2*XLEN-1:0]  beats;
    logic [XLEN-1:0]    assembled;
    logic               sign_bit;
    logic [XLEN-1:0]    load_val;
    logic               is_split;
    logic [ADDR_W-1:0]  aligned;
    logic               resp_load;

    // In IDLE the lane logic looks at the incoming request so beat0 can be
    // registered on accept; afterwards it works from the latched access.
    always_comb begin
        src_addr  = (state == IDLE) ? addr_in       : a_addr;
        src_store = (state == IDLE) ? store_data_in : a_store;
        src_width = (state == IDLE) ? width_in      : a_width;
        sz = src_width[1:0];
        if (XLEN == 32 && sz == 2'd3)
            sz = 2'd2;
        nbytes = 1 << sz;
        nbits  = 8 << sz;
        off    = src_addr[OFF_W-1:0];
        base_mask = '0;
        for (int i = 0; i < 2*LANES; i++)
            if (i < nbytes)
                base_mask[i] = 1'b1;
        full_mask = base_mask << off;
        shifted   = {{XLEN{1'b0}}, src_store} << {off, 3'b000};
        is_split  = |full_mask[2*LANES-1:LANES];
        aligned   = {src_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        beats     = (state == BEAT1) ? {mem_rdata_in, rd_hold} : {{XLEN{1'b0}}, mem_rdata_in};
        assembled = XLEN'(beats >> {off, 3'b000});
        case (sz)
            2'd0:    sign_bit = assembled[7];
            2'd1:    sign_bit = assembled[15];
            2'd2:    sign_bit = assembled[31];
            default: sign_bit = assembled[XLEN-1];
        endcase
        if (src_width[2])
            sign_bit = 1'b0;
        load_val = '0;
        for (int i = 0; i < XLEN; i++)
            load_val[i] = (i < nbits) ? assembled[i] : sign_bit;
        resp_load = mem_ack_in && !kill && !flush_in &&
                    ((state == BEAT0 && !is_split) || state == BEAT1);
    end

    assign req_ready_out = (state == IDLE);
    assign wb_valid_out  = wb_valid_q & ~flush_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            a_addr          <= '0;
            a_store         <= '0;
            a_width         <= '0;
            a_write         <= 1'b0;
            a_rd            <= '0;
            kill            <= 1'b0;
            rd_hold         <= '0;
            mem_req_out     <= 1'b0;
            mem_we_out      <= 1'b0;
            mem_addr_out    <= '0;
            mem_wdata_out   <= '0;
            mem_mask_out    <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_write_out <= 1'b0;
            wb_rd_out       <= '0;
            wb_data_out     <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_in && !flush_in) begin
                        a_addr        <= addr_in;
                        a_store       <= store_data_in;
                        a_width       <= width_in;
                        a_write       <= write_in;
                        a_rd          <= rd_in;
                        kill          <= 1'b0;
                        state         <= BEAT0;
                        mem_req_out   <= 1'b1;
                        mem_we_out    <= write_in;
                        mem_addr_out  <= aligned;
                        mem_wdata_out <= shifted[XLEN-1:0];
                        mem_mask_out  <= full_mask[LANES-1:0];
                    end
                end
                BEAT0: begin
                    if (flush_in)
                        kill <= 1'b1;
                    if (mem_ack_in) begin
                        rd_hold <= mem_rdata_in;
                        if (kill || flush_in) begin
                            state       <= IDLE;
                            mem_req_out <= 1'b0;
                        end else if (is_split) begin
                            state         <= BEAT1;
                            mem_addr_out  <= aligned + ADDR_W'(LANES);
                            mem_wdata_out <= shifted[2*XLEN-1:XLEN];
                            mem_mask_out  <= full_mask[2*LANES-1:LANES];
                        end else begin
                            state       <= RESP;
                            mem_req_out <= 1'b0;
                        end
                    end
                end
                BEAT1: begin
                    if (flush_in)
                        kill <= 1'b1;
                    if (mem_ack_in) begin
                        mem_req_out <= 1'b0;
                        state       <= (kill || flush_in) ? IDLE : RESP;
                    end
                end
                default: state <= IDLE;
            endcase
            if (resp_load) begin
                wb_valid_q      <= 1'b1;
                wb_rd_out       <= a_rd;
                wb_rd_write_out <= !a_write;
                wb_data_out     <= a_write ? '0 : load_val;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (XLEN 64 and 32)
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        v = 0, wr = 0, fl = 0, ak = 0, ready, mreq, mwe, wbv, wbw;
    logic [31:0] ad = 0, maddr;
    logic [63:0] sd = 0, rdat = 0, mwdata, wbdata;
    logic [2:0]  wd = 0;
    logic [4:0]  rdi = 0, wbrd;
    logic [7:0]  mmask;

    logic        v_b = 0, wr_b = 0, fl_b = 0, ak_b = 0, ready_b, mreq_b, mwe_b, wbv_b, wbw_b;
    logic [31:0] ad_b = 0, maddr_b, sd_b = 0, rdat_b = 0, mwdata_b, wbdata_b;
    logic [2:0]  wd_b = 0;
    logic [4:0]  rdi_b = 0, wbrd_b;
    logic [3:0]  mmask_b;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.XLEN(64), .ADDR_W(32)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(v), .req_ready_out(ready),
        .addr_in(ad), .store_data_in(sd), .width_in(wd), .write_in(wr), .rd_in(rdi),
        .flush_in(fl), .mem_req_out(mreq), .mem_we_out(mwe), .mem_addr_out(maddr),
        .mem_wdata_out(mwdata), .mem_mask_out(mmask), .mem_ack_in(ak), .mem_rdata_in(rdat),
        .wb_valid_out(wbv), .wb_rd_write_out(wbw), .wb_rd_out(wbrd), .wb_data_out(wbdata)
    );

    mem_access_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk_in(clk), .rst_n_in(rst_n), .req_valid_in(v_b), .req_ready_out(ready_b),
        .addr_in(ad_b), .store_data_in(sd_b), .width_in(wd_b), .write_in(wr_b), .rd_in(rdi_b),
        .flush_in(fl_b), .mem_req_out(mreq_b), .mem_we_out(mwe_b), .mem_addr_out(maddr_b),
        .mem_wdata_out(mwdata_b), .mem_mask_out(mmask_b), .mem_ack_in(ak_b), .mem_rdata_in(rdat_b),
        .wb_valid_out(wbv_b), .wb_rd_write_out(wbw_b), .wb_rd_out(wbrd_b), .wb_data_out(wbdata_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [63:0] d, input logic [2:0] w,
                         input logic we, input logic [4:0] r);
        ad = a; sd = d; wd = w; wr = we; rdi = r; v = 1;
        step();
        v = 0;
    endtask

    initial begin
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_bus", {mreq, mwe, maddr, mmask}, 0);
        chk("reset_wdata", mwdata, 0);
        chk("reset_wb", {wbv, wbw, wbrd}, 0);
        chk("reset_wbdata", wbdata, 0);
        step(); step();
        rst_n = 1;

        // LB signed at 0x1003
        issue(32'h1003, 64'h0, 3'b000, 0, 5'd5);
        chk("lb_req", {mreq, mwe, ready}, 3'b100);
        chk("lb_addr", maddr, 32'h1000);
        chk("lb_mask", mmask, 8'h08);
        ak = 1; rdat = 64'h0000_0000_8000_0000;
        step();
        ak = 0;
        chk("lb_wbv", {wbv, wbw, wbrd, mreq}, {1'b1, 1'b1, 5'd5, 1'b0});
        chk("lb_data", wbdata, 64'hFFFF_FFFF_FFFF_FF80);
        step();
        chk("lb_done", {wbv, ready}, 2'b01);

        // LBU same access
        issue(32'h1003, 64'h0, 3'b100, 0, 5'd6);
        ak = 1;
        step();
        ak = 0;
        chk("lbu_data", {wbv, wbdata}, {1'b1, 64'h80});
        step();

        // SW at 0x1006 split into two beats
        issue(32'h1006, 64'hAABBCCDD, 3'b010, 1, 5'd7);
        chk("sw_b0_addr", {mreq, mwe, maddr}, {2'b11, 32'h1000});
        chk("sw_b0_mask", mmask, 8'hC0);
        chk("sw_b0_wdata", mwdata[63:48], 16'hCCDD);
        ak = 1;
        step();
        chk("sw_b1_addr", {mreq, mwe, maddr}, {2'b11, 32'h1008});
        chk("sw_b1_mask", mmask, 8'h03);
        chk("sw_b1_wdata", mwdata[15:0], 16'hAABB);
        step();
        ak = 0;
        chk("sw_wb", {wbv, wbw, wbrd, mreq}, {1'b1, 1'b0, 5'd7, 1'b0});
        chk("sw_wbdata", wbdata, 0);
        step();

        // LD at 0x1005 split
        issue(32'h1005, 64'h0, 3'b011, 0, 5'd8);
        chk("ld_b0_mask", {maddr, mmask}, {32'h1000, 8'hE0});
        ak = 1; rdat = 64'h8877665544332211;
        step();
        chk("ld_b1_mask", {mreq, maddr, mmask}, {1'b1, 32'h1008, 8'h1F});
        rdat = 64'h00FF_EEDD_CCBB_AA99;
        step();
        ak = 0;
        chk("ld_data", {wbv, wbdata}, {1'b1, 64'hDDCC_BBAA_9988_7766});
        step();

        // LH at 0x10 with three wait cycles
        issue(32'h10, 64'h0, 3'b001, 0, 5'd9);
        rdat = 64'h0000_0000_0000_1234;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lh_wait_bus", {mreq, mwe, maddr, mmask, ready, wbv}, {2'b10, 32'h10, 8'h03, 2'b00});
        end
        ak = 1;
        step();
        ak = 0;
        chk("lh_wb", {wbv, wbdata}, {1'b1, 64'h1234});
        step();
        chk("lh_after", {wbv, ready, wbdata}, {2'b01, 64'h1234});

        // Flush during split SW beat0
        issue(32'h1006, 64'h11223344, 3'b010, 1, 5'd3);
        fl = 1;
        step();
        fl = 0;
        chk("fl_b0_held", {mreq, maddr, mmask}, {1'b1, 32'h1000, 8'hC0});
        ak = 1;
        step();
        ak = 0;
        chk("fl_after_ack", {mreq, ready, wbv}, 3'b010);
        step();
        chk("fl_no_wb", {mreq, wbv, wbrd}, {2'b00, 5'd9});

        // Request with flush in IDLE is not accepted
        ad = 32'h20; wd = 3'b010; wr = 0; v = 1; fl = 1;
        step();
        v = 0; fl = 0;
        chk("fl_idle", {mreq, ready}, 2'b01);

        // XLEN=32 LW at 0x2
        ad_b = 32'h2; wd_b = 3'b010; wr_b = 0; rdi_b = 5'd12; v_b = 1;
        step();
        v_b = 0;
        chk("w32_b0", {mreq_b, maddr_b, mmask_b}, {1'b1, 32'h0, 4'hC});
        ak_b = 1; rdat_b = 32'hBBAA_0000;
        step();
        chk("w32_b1", {mreq_b, maddr_b, mmask_b}, {1'b1, 32'h4, 4'h3});
        rdat_b = 32'h0000_DDCC;
        step();
        ak_b = 0;
        chk("w32_data", {wbv_b, wbw_b, wbrd_b, wbdata_b}, {2'b11, 5'd12, 32'hDDCC_BBAA});
        step();

        // Asynchronous reset while in BEAT1
        issue(32'h1005, 64'h0, 3'b011, 0, 5'd4);
        ak = 1; rdat = 64'h1;
        step();
        ak = 0;
        chk("rst_pre_b1", {mreq, maddr}, {1'b1, 32'h1008});
        #2 rst_n = 0;
        #1;
        chk("rst_mid_bus", {mreq, mwe, maddr, mmask, ready}, {2'b00, 32'h0, 8'h0, 1'b1});
        chk("rst_mid_wdata", mwdata, 0);
        chk("rst_mid_wb", {wbv, wbw, wbrd, wbdata}, 0);
        step();
        rst_n = 1;
        step();
        chk("rst_stays_idle", {mreq, ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
